// File: rtl/alu_pkg.sv
// ALU op codes, opcode and funct7 constants shared by ID-stage decode and the EX-stage ALU.
// Pure definitions; no timing or flow control.
package alu_pkg;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_SLL  = 4'b0010;
   localparam logic [3:0] ALU_SLT  = 4'b0011;
   localparam logic [3:0] ALU_SLTU = 4'b0100;
   localparam logic [3:0] ALU_XOR  = 4'b0101;
   localparam logic [3:0] ALU_SRL  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_OR   = 4'b1000;
   localparam logic [3:0] ALU_AND  = 4'b1001;
   localparam logic [3:0] ALU_MUL  = 4'b1010;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef struct packed {
      logic [3:0] alu;
      logic       src_imm;
      logic       src_pc;
      logic       illegal;
      logic       rs1_zero;
   } dec_t;

   // Base funct3 -> op map shared by OP and OP-IMM (alternate encodings handled by caller).
   function automatic logic [3:0] base_alu(input logic [2:0] funct3);
      logic [3:0] op;
      case (funct3)
         3'b000:  op = ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate extraction; format chosen by opcode, sign-extended to DATA_WIDTH.
// Zero latency; no flow control. Formats without an immediate yield 0.
module imm_gen
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [31:0]           instr,
   output logic [DATA_WIDTH-1:0] imm
);

   logic [31:0] imm32;

   always_comb begin
      imm32 = '0;
      case (instr[6:0])
         OPC_OP_IMM, OPC_LOAD, OPC_JALR:
            imm32 = {{20{instr[31]}}, instr[31:20]};
         OPC_STORE:
            imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         OPC_BRANCH:
            imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
         OPC_LUI, OPC_AUIPC:
            imm32 = {instr[31:12], 12'b0};
         OPC_JAL:
            imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
         default:
            imm32 = '0;
      endcase
   end

   assign imm = DATA_WIDTH'($signed(imm32));

endmodule

// File: rtl/alu_ctrl_id_ex.sv
// ID-stage decode of ALU control into the ID/EX register; one-cycle latency, registered outputs only.
// stall_i holds the register, flush_i (priority over stall) or an invalid input loads a bubble.
module alu_ctrl_id_ex
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           instr_IF_ID_i,
   input  logic [DATA_WIDTH-1:0] pc_IF_ID_i,
   input  logic                  valid_IF_ID_i,
   input  logic                  stall_i,
   input  logic                  flush_i,
   output logic [3:0]            alu_ctrl_ID_EX_o,
   output logic                  alu_src_imm_ID_EX_o,
   output logic                  alu_src_pc_ID_EX_o,
   output logic [DATA_WIDTH-1:0] imm_ID_EX_o,
   output logic [DATA_WIDTH-1:0] pc_ID_EX_o,
   output logic [REG_ADDR_W-1:0] rs1_ID_EX_o,
   output logic [REG_ADDR_W-1:0] rs2_ID_EX_o,
   output logic [REG_ADDR_W-1:0] rd_ID_EX_o,
   output logic                  valid_ID_EX_o,
   output logic                  illegal_ID_EX_o
);

   logic [6:0]            opcode;
   logic [2:0]            funct3;
   logic [6:0]            funct7;
   logic [DATA_WIDTH-1:0] imm;
   dec_t                  dec;

   assign opcode = instr_IF_ID_i[6:0];
   assign funct3 = instr_IF_ID_i[14:12];
   assign funct7 = instr_IF_ID_i[31:25];

   imm_gen #(.DATA_WIDTH(DATA_WIDTH)) u_imm_gen (
      .instr (instr_IF_ID_i),
      .imm   (imm)
   );

   always_comb begin
      dec = '{alu: ALU_ADD, src_imm: 1'b0, src_pc: 1'b0, illegal: 1'b0, rs1_zero: 1'b0};
      case (opcode)
         OPC_OP: begin
            case (funct7)
               F7_BASE:   dec.alu = base_alu(funct3);
               F7_ALT: begin
                  if (funct3 == 3'b000)      dec.alu = ALU_SUB;
                  else if (funct3 == 3'b101) dec.alu = ALU_SRA;
                  else                       dec.illegal = 1'b1;
               end
               F7_MULDIV: begin
                  if (funct3 == 3'b000) dec.alu = ALU_MUL;
                  else                  dec.illegal = 1'b1;
               end
               default:   dec.illegal = 1'b1;
            endcase
         end
         OPC_OP_IMM: begin
            dec.src_imm = 1'b1;
            // Shift-immediates reuse imm[11:5] as funct7; anything else there is a bad encoding.
            case (funct3)
               3'b001: begin
                  if (funct7 == F7_BASE) dec.alu = ALU_SLL;
                  else                   dec.illegal = 1'b1;
               end
               3'b101: begin
                  if (funct7 == F7_BASE)     dec.alu = ALU_SRL;
                  else if (funct7 == F7_ALT) dec.alu = ALU_SRA;
                  else                       dec.illegal = 1'b1;
               end
               default: dec.alu = base_alu(funct3);
            endcase
         end
         OPC_LOAD, OPC_STORE, OPC_JALR: dec.src_imm = 1'b1;
         OPC_AUIPC, OPC_JAL: begin
            dec.src_imm = 1'b1;
            dec.src_pc  = 1'b1;
         end
         OPC_LUI: begin
            dec.src_imm  = 1'b1;
            dec.rs1_zero = 1'b1;
         end
         OPC_BRANCH: begin
            case (funct3)
               3'b000, 3'b001: dec.alu = ALU_SUB;
               3'b100, 3'b101: dec.alu = ALU_SLT;
               3'b110, 3'b111: dec.alu = ALU_SLTU;
               default:        dec.illegal = 1'b1;
            endcase
         end
         default: dec.illegal = 1'b1;
      endcase
      if (dec.illegal) begin
         dec.alu     = ALU_ADD;
         dec.src_imm = 1'b0;
         dec.src_pc  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush_i || (!stall_i && !valid_IF_ID_i)) begin
         alu_ctrl_ID_EX_o    <= ALU_ADD;
         alu_src_imm_ID_EX_o <= 1'b0;
         alu_src_pc_ID_EX_o  <= 1'b0;
         imm_ID_EX_o         <= '0;
         pc_ID_EX_o          <= '0;
         rs1_ID_EX_o         <= '0;
         rs2_ID_EX_o         <= '0;
         rd_ID_EX_o          <= '0;
         valid_ID_EX_o       <= 1'b0;
         illegal_ID_EX_o     <= 1'b0;
      end else if (!stall_i) begin
         // Illegal instructions keep their PC so EX can raise the trap.
         alu_ctrl_ID_EX_o    <= dec.alu;
         alu_src_imm_ID_EX_o <= dec.src_imm;
         alu_src_pc_ID_EX_o  <= dec.src_pc;
         imm_ID_EX_o         <= imm;
         pc_ID_EX_o          <= pc_IF_ID_i;
         rs1_ID_EX_o         <= dec.rs1_zero ? '0 : REG_ADDR_W'(instr_IF_ID_i[19:15]);
         rs2_ID_EX_o         <= REG_ADDR_W'(instr_IF_ID_i[24:20]);
         rd_ID_EX_o          <= REG_ADDR_W'(instr_IF_ID_i[11:7]);
         valid_ID_EX_o       <= ~dec.illegal;
         illegal_ID_EX_o     <= dec.illegal;
      end
   end

endmodule

// File: tb/tb_alu_ctrl_id_ex.sv
// Bench for alu_ctrl_id_ex: directed literal checks plus randomized traffic against an
// encoding-pattern reference model, compared every cycle on the falling edge.
module tb_alu_ctrl_id_ex;

   localparam int DW = 32;
   localparam int RW = 5;

   localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLL = 4'd2, A_SLT = 4'd3,
                          A_SLTU = 4'd4, A_XOR = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7,
                          A_OR = 4'd8, A_AND = 4'd9, A_MUL = 4'd10;

   localparam int F_NONE = 0, F_I = 1, F_S = 2, F_B = 3, F_U = 4, F_J = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [31:0]   instr = '0;
   logic [DW-1:0] pc = '0;
   logic          vin = 1'b0, stall = 1'b0, flush = 1'b0;
   logic [3:0]    alu;
   logic          simm, spc, vout, ill;
   logic [DW-1:0] imm, pco;
   logic [RW-1:0] rs1, rs2, rd;

   alu_ctrl_id_ex #(.DATA_WIDTH(DW), .REG_ADDR_W(RW)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .instr_IF_ID_i       (instr),
      .pc_IF_ID_i          (pc),
      .valid_IF_ID_i       (vin),
      .stall_i             (stall),
      .flush_i             (flush),
      .alu_ctrl_ID_EX_o    (alu),
      .alu_src_imm_ID_EX_o (simm),
      .alu_src_pc_ID_EX_o  (spc),
      .imm_ID_EX_o         (imm),
      .pc_ID_EX_o          (pco),
      .rs1_ID_EX_o         (rs1),
      .rs2_ID_EX_o         (rs2),
      .rd_ID_EX_o          (rd),
      .valid_ID_EX_o       (vout),
      .illegal_ID_EX_o     (ill)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual %h required %h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Reference decoder: instruction encodings as mask/match patterns.
   typedef struct {
      logic [31:0] mask;
      logic [31:0] match;
      logic [3:0]  op;
      bit          si;
      bit          sp;
      bit          lui;
      int          fmt;
   } pat_t;
   pat_t pats[$];

   typedef struct packed {
      logic [3:0]  op;
      logic        si;
      logic        sp;
      logic        il;
      logic [31:0] im;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic [4:0]  d;
   } mres_t;

   function automatic void addp(input logic [31:0] m, input logic [31:0] v, input logic [3:0] op,
                                input bit si, input bit sp, input bit lui, input int fmt);
      pat_t p;
      p.mask = m; p.match = v; p.op = op; p.si = si; p.sp = sp; p.lui = lui; p.fmt = fmt;
      pats.push_back(p);
   endfunction

   function automatic logic [31:0] calc_imm(input logic [31:0] ins, input int fmt);
      int s, r;
      s = int'(ins);
      case (fmt)
         F_I: r = s >>> 20;
         F_S: r = (s >>> 25) * 32 + int'((ins >> 7) & 31);
         F_B: r = (s >>> 31) * 4096 + int'((ins >> 7) & 1) * 2048
                  + int'((ins >> 25) & 63) * 32 + int'((ins >> 8) & 15) * 2;
         F_U: r = int'(ins & 32'hFFFFF000);
         F_J: r = (s >>> 31) * (1 << 20) + int'((ins >> 12) & 255) * 4096
                  + int'((ins >> 20) & 1) * 2048 + int'((ins >> 21) & 1023) * 2;
         default: r = 0;
      endcase
      return 32'(r);
   endfunction

   function automatic mres_t model(input logic [31:0] ins);
      mres_t r;
      r = '0;
      r.il = 1'b1;
      r.r2 = ins[24:20];
      r.d  = ins[11:7];
      foreach (pats[i]) begin
         if ((ins & pats[i].mask) == pats[i].match) begin
            r.il = 1'b0;
            r.op = pats[i].op;
            r.si = pats[i].si;
            r.sp = pats[i].sp;
            r.r1 = pats[i].lui ? 5'd0 : ins[19:15];
            r.im = calc_imm(ins, pats[i].fmt);
         end
      end
      return r;
   endfunction

   initial begin
      logic [3:0] base [8];
      base = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
      for (int f = 0; f < 8; f++)
         addp(32'hFE00707F, (32'(f) << 12) | 32'h33, base[f], 0, 0, 0, F_NONE);
      addp(32'hFE00707F, 32'h40000033, A_SUB, 0, 0, 0, F_NONE);
      addp(32'hFE00707F, 32'h40005033, A_SRA, 0, 0, 0, F_NONE);
      addp(32'hFE00707F, 32'h02000033, A_MUL, 0, 0, 0, F_NONE);
      for (int f = 0; f < 8; f++)
         if (f != 1 && f != 5)
            addp(32'h0000707F, (32'(f) << 12) | 32'h13, base[f], 1, 0, 0, F_I);
      addp(32'hFE00707F, 32'h00001013, A_SLL, 1, 0, 0, F_I);
      addp(32'hFE00707F, 32'h00005013, A_SRL, 1, 0, 0, F_I);
      addp(32'hFE00707F, 32'h40005013, A_SRA, 1, 0, 0, F_I);
      addp(32'h7F, 32'h03, A_ADD, 1, 0, 0, F_I);
      addp(32'h7F, 32'h23, A_ADD, 1, 0, 0, F_S);
      addp(32'h7F, 32'h67, A_ADD, 1, 0, 0, F_I);
      addp(32'h7F, 32'h17, A_ADD, 1, 1, 0, F_U);
      addp(32'h7F, 32'h6F, A_ADD, 1, 1, 0, F_J);
      addp(32'h7F, 32'h37, A_ADD, 1, 0, 1, F_U);
      for (int f = 0; f < 8; f++)
         if (f != 2 && f != 3)
            addp(32'h0000707F, (32'(f) << 12) | 32'h63,
                 (f < 2) ? A_SUB : (f < 6) ? A_SLT : A_SLTU, 0, 0, 0, F_B);
   end

   // Expected register contents, advanced on each rising edge.
   bit          started = 0;
   logic [3:0]  e_op;
   logic        e_si, e_sp, e_v, e_il;
   logic [31:0] e_im, e_pc;
   logic [4:0]  e_r1, e_r2, e_d;

   always @(posedge clk) begin
      mres_t m;
      if (rst || flush || (!stall && !vin)) begin
         started = started | rst;
         e_op = A_ADD; e_si = 0; e_sp = 0; e_v = 0; e_il = 0;
         e_im = 0; e_pc = 0; e_r1 = 0; e_r2 = 0; e_d = 0;
      end else if (!stall) begin
         m = model(instr);
         e_il = m.il;
         e_v  = !m.il;
         e_pc = pc;
         e_op = m.il ? A_ADD : m.op;
         e_si = m.il ? 1'b0 : m.si;
         e_sp = m.il ? 1'b0 : m.sp;
         e_im = m.im; e_r1 = m.r1; e_r2 = m.r2; e_d = m.d;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("valid", 32'(vout), 32'(e_v));
         chk("illegal", 32'(ill), 32'(e_il));
         chk("alu_ctrl", 32'(alu), 32'(e_op));
         if (!e_il) begin
            chk("src_imm", 32'(simm), 32'(e_si));
            chk("src_pc", 32'(spc), 32'(e_sp));
         end
         if (e_v || e_il) chk("pc", pco, e_pc);
         if (e_v) begin
            chk("imm", imm, e_im);
            chk("rs1", 32'(rs1), 32'(e_r1));
            chk("rs2", 32'(rs2), 32'(e_r2));
            chk("rd", 32'(rd), 32'(e_d));
         end
      end
   end

   // One cycle: drive at the falling edge, let a rising edge pass, return at the next falling edge.
   task automatic step(input logic [31:0] i, input logic v, input logic st,
                       input logic fl, input logic r);
      instr = i; vin = v; stall = st; flush = fl; rst = r;
      pc = pc + 4;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic lit(input string nm, input logic [31:0] dv, input logic [31:0] mv,
                      input logic [31:0] want);
      chk({nm, "_dut"}, dv, want);
      chk({nm, "_model"}, mv, want);
   endtask

   initial begin
      logic [31:0] held_pc;
      logic [6:0]  opcs [10];
      logic [6:0]  f7s [4];
      logic [31:0] ri;
      opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h67, 7'h17, 7'h6F, 7'h37, 7'h63, 7'h33};
      f7s  = '{7'h00, 7'h20, 7'h01, 7'h00};

      @(negedge clk);
      step(32'h0, 0, 0, 0, 1);
      step(32'h0, 0, 0, 0, 1);
      lit("rst_alu", 32'(alu), 32'(e_op), 0);
      lit("rst_valid", 32'(vout), 32'(e_v), 0);
      lit("rst_pc", pco, e_pc, 0);
      lit("rst_imm", imm, e_im, 0);

      step(32'h002081B3, 1, 0, 0, 0);
      lit("add_alu", 32'(alu), 32'(e_op), 0);
      lit("add_simm", 32'(simm), 32'(e_si), 0);
      lit("add_rs1", 32'(rs1), 32'(e_r1), 1);
      lit("add_rs2", 32'(rs2), 32'(e_r2), 2);
      lit("add_rd", 32'(rd), 32'(e_d), 3);
      lit("add_valid", 32'(vout), 32'(e_v), 1);

      step(32'h402081B3, 1, 0, 0, 0);
      lit("sub_alu", 32'(alu), 32'(e_op), 1);
      step(32'h40335293, 1, 0, 0, 0);
      lit("srai_alu", 32'(alu), 32'(e_op), 7);
      lit("srai_imm", imm, e_im, 32'h00000403);
      lit("srai_simm", 32'(simm), 32'(e_si), 1);

      step(32'h029403B3, 1, 0, 0, 0);
      lit("mul_alu", 32'(alu), 32'(e_op), 10);
      step(32'h029443B3, 1, 0, 0, 0);
      lit("div_ill", 32'(ill), 32'(e_il), 1);
      lit("div_valid", 32'(vout), 32'(e_v), 0);
      lit("div_alu", 32'(alu), 32'(e_op), 0);

      step(32'hFFF00093, 1, 0, 0, 0);
      held_pc = pc;
      for (int k = 0; k < 3; k++) begin
         step(32'h402081B3, 1, 1, 0, 0);
         lit("stall_imm", imm, e_im, 32'hFFFFFFFF);
         lit("stall_alu", 32'(alu), 32'(e_op), 0);
         lit("stall_rd", 32'(rd), 32'(e_d), 1);
         lit("stall_pc", pco, e_pc, held_pc);
      end
      step(32'h402081B3, 1, 0, 0, 0);
      lit("unstall_alu", 32'(alu), 32'(e_op), 1);

      step(32'h402081B3, 1, 1, 1, 0);
      lit("flstall_valid", 32'(vout), 32'(e_v), 0);
      lit("flstall_alu", 32'(alu), 32'(e_op), 0);

      step(32'h029403B3, 1, 0, 0, 0);
      step(32'h002081B3, 1, 1, 0, 1);
      lit("midrst_alu", 32'(alu), 32'(e_op), 0);
      lit("midrst_rd", 32'(rd), 32'(e_d), 0);
      lit("midrst_pc", pco, e_pc, 0);
      step(32'h402081B3, 1, 0, 0, 0);
      lit("postrst_alu", 32'(alu), 32'(e_op), 1);
      lit("postrst_valid", 32'(vout), 32'(e_v), 1);

      for (int n = 0; n < 4000; n++) begin
         ri = $urandom;
         if ($urandom_range(9) != 0) begin
            ri[6:0]   = opcs[$urandom_range(9)];
            if ($urandom_range(3) != 0) ri[31:25] = f7s[$urandom_range(3)];
         end
         step(ri, $urandom_range(99) < 85, $urandom_range(99) < 15,
              $urandom_range(99) < 8, $urandom_range(99) < 2);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
